// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed two-PMOD 7-segment watch display.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Segment patterns are bit-ordered g..a, active-high. The same table is
// used by the display driver, so both sides always agree on the encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h27;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Largest legal value for a units digit and for a tens digit (MM:SS).
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    // Scan tracking FSM.
    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        SETTLE    = 2'd1,
        CAPTURE   = 2'd2
    } scan_state_t;

    // One complete MM:SS reading.
    typedef struct packed {
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } bcd_time_t;

    // True when a decoded digit is legal for its position.
    function automatic logic digit_in_range(input logic [3:0] digit,
                                            input logic       tens_pos);
        if (tens_pos) begin
            return digit <= BCD_TENS_MAX;
        end
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Segment pattern to BCD digit decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   seg   - 7-bit segment pattern, g..a, active-high
//   vld   - 1 when seg is one of the ten legal digit patterns
//   digit - decoded value 0..9 (0 when vld is low)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       vld,
    output logic [3:0] digit
);

    always_comb begin
        vld   = 1'b1;
        digit = 4'd0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: vld   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed two-PMOD watch display: samples both PMODs,
// follows the digit-select phase, decodes segments and publishes MM:SS frames.
// Latency: SYNC_STAGES + SETTLE_CYCLES + 2 cycles from a raw phase-1 select
// edge to upd. Backpressure: none; the display free-runs, frames are dropped
// rather than stalled.
//
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   pmod_a[7] / pmod_b[7]    - digit select as seen on each PMOD
//   pmod_a[6:0]              - minutes digit segments (g..a)
//   pmod_b[6:0]              - seconds digit segments (g..a)
//   clr_err                  - one-cycle pulse, clears sticky error flags
//   sec0, sec1, min0, min1   - last published BCD time
//   time_vld                 - a frame has been published since reset
//   upd                      - one-cycle pulse when the published time changes
//   locked                   - select edges are still arriving
//   err_pat, err_sel         - sticky pattern / select-mismatch errors
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,       // must be >= 2
    parameter int SETTLE_CYCLES = 16,      // must be >= 1
    parameter int STALE_CYCLES  = 262144
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pmod_a,
    input  logic [7:0] pmod_b,
    input  logic       clr_err,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic       time_vld,
    output logic       upd,
    output logic       locked,
    output logic       err_pat,
    output logic       err_sel
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STALE_W  = $clog2(STALE_CYCLES + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STALE_W-1:0]  STALE_MAX   = STALE_W'(STALE_CYCLES);

    // ------------------------------------------------------------------
    // Input synchronizers. The display is driven from an unrelated clock,
    // so every bit gets its own flop chain.
    // ------------------------------------------------------------------
    logic [7:0] sync_a [SYNC_STAGES];
    logic [7:0] sync_b [SYNC_STAGES];
    logic [7:0] sa;
    logic [7:0] sb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_a[i] <= '0;
                sync_b[i] <= '0;
            end
        end else begin
            sync_a[0] <= pmod_a;
            sync_b[0] <= pmod_b;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_a[i] <= sync_a[i-1];
                sync_b[i] <= sync_b[i-1];
            end
        end
    end

    assign sa = sync_a[SYNC_STAGES-1];
    assign sb = sync_b[SYNC_STAGES-1];

    // Select edge detection. Only the minutes PMOD select drives the phase;
    // the seconds select is only cross-checked at sample time.
    logic prev_sel;
    logic sel_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel <= 1'b0;
        end else begin
            prev_sel <= sa[7];
        end
    end

    assign sel_edge = sa[7] ^ prev_sel;

    // ------------------------------------------------------------------
    // Scan FSM: wait for a select edge, let the segments settle, then
    // sample for exactly one cycle.
    // ------------------------------------------------------------------
    scan_state_t         state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
    logic                phase, phase_nxt;
    logic                capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_EDGE;
            settle_cnt <= '0;
            phase      <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            phase      <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        phase_nxt      = phase;
        capture        = 1'b0;
        case (state)
            WAIT_EDGE: begin
                if (sel_edge) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                    phase_nxt      = sa[7];
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                // A further edge means the select glitched or the scan
                // moved on: restart the settle window on the newest phase.
                if (sel_edge) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                    phase_nxt      = sa[7];
                end else if (settle_cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = WAIT_EDGE;
            end
            default: begin
                state_nxt = WAIT_EDGE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Segment decode and capture classification.
    // ------------------------------------------------------------------
    logic       a_vld, b_vld;
    logic [3:0] a_dig, b_dig;

    seg7_decode u_dec_a (
        .seg   (sa[6:0]),
        .vld   (a_vld),
        .digit (a_dig)
    );

    seg7_decode u_dec_b (
        .seg   (sb[6:0]),
        .vld   (b_vld),
        .digit (b_dig)
    );

    logic pat_bad;
    logic sel_err_set;
    logic pat_err_set;
    logic stage0;
    logic publish;
    logic have0;

    // In phase 1 both digits are tens digits (minutes tens, seconds tens).
    assign pat_bad = !a_vld || !b_vld
                   || !digit_in_range(a_dig, phase)
                   || !digit_in_range(b_dig, phase);

    assign sel_err_set = capture && (sa[7] != sb[7]);
    assign pat_err_set = capture && (sa[7] == sb[7]) && pat_bad;
    assign stage0      = capture && (sa[7] == sb[7]) && !pat_bad && !phase;
    // Phase 1 without a good phase 0 before it is dropped silently.
    assign publish     = capture && (sa[7] == sb[7]) && !pat_bad && phase && have0;

    // Units digits are held here until the matching tens digits arrive.
    logic [3:0] stg_sec0;
    logic [3:0] stg_min0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have0    <= 1'b0;
            stg_sec0 <= '0;
            stg_min0 <= '0;
        end else begin
            if (sel_err_set || pat_err_set || publish) begin
                have0 <= 1'b0;
            end else if (stage0) begin
                have0    <= 1'b1;
                stg_sec0 <= b_dig;
                stg_min0 <= a_dig;
            end
        end
    end

    // ------------------------------------------------------------------
    // Publish: outputs change only here, one cycle after CAPTURE.
    // ------------------------------------------------------------------
    bcd_time_t new_time;
    bcd_time_t time_q;

    always_comb begin
        new_time.min1 = a_dig;
        new_time.min0 = stg_min0;
        new_time.sec1 = b_dig;
        new_time.sec0 = stg_sec0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q   <= '0;
            time_vld <= 1'b0;
            upd      <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (publish) begin
                time_q   <= new_time;
                time_vld <= 1'b1;
                // The first publish always announces itself, even if the
                // time happens to read 00:00.
                upd      <= !time_vld || (new_time != time_q);
            end
        end
    end

    assign sec0 = time_q.sec0;
    assign sec1 = time_q.sec1;
    assign min0 = time_q.min0;
    assign min1 = time_q.min1;

    // ------------------------------------------------------------------
    // Sticky errors: a new error in the same cycle as clr_err survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pat <= 1'b0;
            err_sel <= 1'b0;
        end else begin
            if (pat_err_set) begin
                err_pat <= 1'b1;
            end else if (clr_err) begin
                err_pat <= 1'b0;
            end
            if (sel_err_set) begin
                err_sel <= 1'b1;
            end else if (clr_err) begin
                err_sel <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock tracking. seen_edge keeps locked low between reset and the first
    // edge, when the stale counter still reads 0.
    // ------------------------------------------------------------------
    logic [STALE_W-1:0] stale_cnt;
    logic               seen_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt <= '0;
            seen_edge <= 1'b0;
        end else begin
            if (sel_edge) begin
                stale_cnt <= '0;
                seen_edge <= 1'b1;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
            end
        end
    end

    assign locked = seen_edge && (stale_cnt < STALE_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int SYNC   = 2;
    localparam int SETTLE = 16;
    localparam int STALE  = 400;
    localparam int LAT    = SYNC + SETTLE + 2;   // raw select change -> upd
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pmod_a = '0;
    logic [7:0] pmod_b = '0;
    logic       clr_err = 1'b0;
    logic [3:0] sec0, sec1, min0, min1;
    logic       time_vld, upd, locked, err_pat, err_sel;

    seg7_scan_decoder #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .STALE_CYCLES  (STALE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pmod_a   (pmod_a),
        .pmod_b   (pmod_b),
        .clr_err  (clr_err),
        .sec0     (sec0),
        .sec1     (sec1),
        .min0     (min0),
        .min1     (min1),
        .time_vld (time_vld),
        .upd      (upd),
        .locked   (locked),
        .err_pat  (err_pat),
        .err_sel  (err_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_cyc = -1;
    int drive_cyc = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (upd === 1'b1) begin upd_cnt++; upd_cyc = cyc; end

    // Reference model, one step per display phase.
    int m_t [4];          // sec0, sec1, min0, min1
    bit m_vld, m_have0, m_errp, m_errs;
    int m_st_s0, m_st_m0;
    bit cur_sel;

    function automatic int dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (SEG_TAB[i] == p) return i;
        return -1;
    endfunction

    function automatic int model_phase(input bit sel, input bit bsel,
                                       input logic [6:0] ap, input logic [6:0] bp);
        int da, db;
        bit chg;
        da = dec(ap);
        db = dec(bp);
        if (sel != bsel) begin m_errs = 1; m_have0 = 0; return 0; end
        if (da < 0 || db < 0 || (sel && (da > 5 || db > 5))) begin
            m_errp = 1; m_have0 = 0; return 0;
        end
        if (!sel) begin m_st_m0 = da; m_st_s0 = db; m_have0 = 1; return 0; end
        if (!m_have0) return 0;
        m_have0 = 0;
        chg = !m_vld || m_t[0] != m_st_s0 || m_t[1] != db || m_t[2] != m_st_m0 || m_t[3] != da;
        m_t[0] = m_st_s0; m_t[1] = db; m_t[2] = m_st_m0; m_t[3] = da;
        m_vld = 1;
        return chg ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit exp_locked);
        chk({tag, ".sec0"}, 32'(sec0), m_t[0]);
        chk({tag, ".sec1"}, 32'(sec1), m_t[1]);
        chk({tag, ".min0"}, 32'(min0), m_t[2]);
        chk({tag, ".min1"}, 32'(min1), m_t[3]);
        chk({tag, ".time_vld"}, 32'(time_vld), 32'(m_vld));
        chk({tag, ".err_pat"}, 32'(err_pat), 32'(m_errp));
        chk({tag, ".err_sel"}, 32'(err_sel), 32'(m_errs));
        chk({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    endtask

    task automatic drive(input bit sel, input logic [6:0] ap, input logic [6:0] bp, input bit bsel);
        @(posedge clk); #1;
        pmod_a = {sel, ap};
        pmod_b = {bsel, bp};
        drive_cyc = cyc;
        cur_sel = sel;
    endtask

    // One display phase held for 'hold' cycles. clr_at >= 0 pulses clr_err so
    // that it lands on the same edge that records the capture result.
    task automatic phase(input string tag, input bit sel, input logic [6:0] ap,
                         input logic [6:0] bp, input bit bsel, input int hold, input int clr_at);
        int u0, eu;
        u0 = upd_cnt;
        drive(sel, ap, bp, bsel);
        if (clr_at >= 0) begin m_errp = 0; m_errs = 0; end
        eu = model_phase(sel, bsel, ap, bp);
        for (int c = 1; c <= hold; c++) begin
            @(posedge clk); #1;
            clr_err = (c == clr_at);
        end
        clr_err = 1'b0;
        @(negedge clk); #1;
        chk({tag, ".upd_count"}, upd_cnt - u0, eu);
        if (eu == 1) chk({tag, ".upd_latency"}, upd_cyc - drive_cyc, LAT);
        check_state(tag, 1'b1);
    endtask

    task automatic frame(input string tag, input int mm, input int ss, input int hold);
        phase({tag, ".p0"}, 1'b0, SEG_TAB[mm % 10], SEG_TAB[ss % 10], 1'b0, hold, -1);
        phase({tag, ".p1"}, 1'b1, SEG_TAB[mm / 10], SEG_TAB[ss / 10], 1'b1, hold, -1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        m_errp = 0; m_errs = 0;
    endtask

    initial begin
        int u0, rm, rs, fault, hold;
        bit sel, bsel;
        logic [6:0] ap, bp;
        for (int i = 0; i < 4; i++) m_t[i] = 0;
        m_vld = 0; m_have0 = 0; m_errp = 0; m_errs = 0; m_st_s0 = 0; m_st_m0 = 0;
        cur_sel = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.upd", 32'(upd), 0);
        check_state("reset", 1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_state("pre_edge", 1'b0);

        // 12:34 scan: leading phase 1 has no phase 0 and is discarded.
        phase("scan_lead", 1'b1, SEG_TAB[1], SEG_TAB[3], 1'b1, 64, -1);
        frame("t1234_a", 12, 34, 64);
        frame("t1234_b", 12, 34, 64);
        frame("t1234_c", 12, 34, 64);

        // Seconds change -> exactly one upd after the next full frame.
        frame("t1235_a", 12, 35, 64);
        frame("t1235_b", 12, 35, 64);

        // Back to 12:34, then digit 8 in a tens position.
        frame("t1234_d", 12, 34, 64);
        phase("tens8.p0", 1'b0, SEG_TAB[2], SEG_TAB[4], 1'b0, 64, -1);
        phase("tens8.p1", 1'b1, SEG_TAB[1], 7'h7F, 1'b1, 64, -1);
        pulse_clr();
        @(negedge clk); #1;
        check_state("clr_pat", 1'b1);

        // Select mismatch at sample time, then mismatch coincident with clr_err.
        phase("mis1.p0", 1'b0, SEG_TAB[2], SEG_TAB[4], 1'b0, 64, -1);
        phase("mis1.p1", 1'b1, SEG_TAB[1], SEG_TAB[3], 1'b0, 64, -1);
        phase("mis2.p0", 1'b0, SEG_TAB[2], SEG_TAB[4], 1'b0, 64, -1);
        phase("mis2.p1", 1'b1, SEG_TAB[1], SEG_TAB[3], 1'b0, 64, LAT - 1);
        pulse_clr();
        @(negedge clk); #1;
        check_state("clr_sel", 1'b1);

        // Select glitch: three edges within 5 cycles, one capture after the last.
        phase("glitch.p0", 1'b0, SEG_TAB[0], SEG_TAB[7], 1'b0, 64, -1);
        u0 = upd_cnt;
        drive(1'b1, SEG_TAB[4], SEG_TAB[5], 1'b1);
        @(posedge clk);
        drive(1'b0, SEG_TAB[0], SEG_TAB[7], 1'b0);
        @(posedge clk);
        drive(1'b1, SEG_TAB[4], SEG_TAB[5], 1'b1);
        void'(model_phase(1'b1, 1'b1, SEG_TAB[4], SEG_TAB[5]));
        repeat (64) @(posedge clk);
        @(negedge clk); #1;
        chk("glitch.upd_count", upd_cnt - u0, 1);
        chk("glitch.upd_latency", upd_cyc - drive_cyc, LAT);
        check_state("glitch", 1'b1);

        // Randomized scan with occasional faults.
        rm = 40; rs = 7;
        for (int i = 0; i < 60; i++) begin
            sel = ~cur_sel;
            if (!sel && $urandom_range(0, 2) != 0) begin
                rm = $urandom_range(0, 59);
                rs = $urandom_range(0, 59);
            end
            ap = sel ? SEG_TAB[rm / 10] : SEG_TAB[rm % 10];
            bp = sel ? SEG_TAB[rs / 10] : SEG_TAB[rs % 10];
            bsel = sel;
            fault = $urandom_range(0, 11);
            if (fault == 0) ap = 7'($urandom);
            else if (fault == 1) bsel = ~sel;
            else if (fault == 2 && sel) bp = SEG_TAB[$urandom_range(6, 9)];
            hold = $urandom_range(30, 70);
            phase($sformatf("rnd%0d", i), sel, ap, bp, bsel, hold, -1);
            if ($urandom_range(0, 5) == 0) pulse_clr();
        end

        // Stop toggling: lock drops, published state holds.
        repeat (STALE + 20) @(posedge clk);
        @(negedge clk); #1;
        check_state("stale", 1'b0);

        // Reset asserted mid-SETTLE takes effect immediately.
        drive(~cur_sel, SEG_TAB[1], SEG_TAB[2], ~cur_sel);
        repeat (SYNC + 5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_t[i] = 0;
        m_vld = 0; m_errp = 0; m_errs = 0;
        chk("async_rst.upd", 32'(upd), 0);
        check_state("async_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
